// File: rtl/tri_fork_join_pkg.sv
// Shared types for the triangle fork/join dispatcher: FSM states, joined result record, stats width.
// Default result widths match the top-level parameter defaults.
package tri_fork_join_pkg;

   localparam int STAT_WIDTH      = 16;
   localparam int DEF_TRI_ID_WIDTH = 11;
   localparam int DEF_GEO_WIDTH    = 168;
   localparam int DEF_COLOR_WIDTH  = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_TRI_ID_WIDTH-1:0] tri_id;
      logic [DEF_GEO_WIDTH-1:0]    geo;
      logic [DEF_COLOR_WIDTH-1:0]  color;
   } tri_result_t;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + STAT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/tri_fork_join_out_fifo.sv
// Synchronous FIFO of joined results, one-cycle push-to-visible, head held until popped.
// Head reads as zero while empty; a pop of an empty FIFO is ignored.
module tri_out_fifo
   import tri_fork_join_pkg::*;
#(
   parameter type T     = tri_result_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output T                         head,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   assign head      = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tri_fork_join.sv
// Forks each triangle to geometry and shade engines, joins results into an output FIFO; cull or watchdog aborts.
// Start pulses one cycle after accept; ready_out only in IDLE with FIFO space. Optional stats ports: TRI_FORK_JOIN_STATS_EN.
module tri_fork_join
   import tri_fork_join_pkg::*;
#(
   parameter int TRI_ID_WIDTH   = 11,
   parameter int GEO_WIDTH      = 168,
   parameter int COLOR_WIDTH    = 16,
   parameter int OUT_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic [TRI_ID_WIDTH-1:0] tri_id_in,
   output logic                    geo_start_out,
   output logic                    shade_start_out,
   output logic                    abort_out,
   input  logic                    geo_valid_in,
   input  logic [GEO_WIDTH-1:0]    geo_data_in,
   input  logic                    geo_cull_in,
   input  logic                    shade_valid_in,
   input  logic [COLOR_WIDTH-1:0]  shade_data_in,
   input  logic                    shade_cull_in,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic [TRI_ID_WIDTH-1:0] tri_id_out,
   output logic [GEO_WIDTH-1:0]    geo_out,
`ifdef TRI_FORK_JOIN_STATS_EN
   output logic [STAT_WIDTH-1:0]   accepted_count_out,
   output logic [STAT_WIDTH-1:0]   cull_count_out,
   output logic [STAT_WIDTH-1:0]   timeout_count_out,
`endif
   output logic [COLOR_WIDTH-1:0]  color_out
);

   typedef struct packed {
      logic [TRI_ID_WIDTH-1:0] tri_id;
      logic [GEO_WIDTH-1:0]    geo;
      logic [COLOR_WIDTH-1:0]  color;
   } result_t;

   localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
   localparam int WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   state_t                  state;
   logic [TRI_ID_WIDTH-1:0] id_q;
   logic [GEO_WIDTH-1:0]    geo_q;
   logic [COLOR_WIDTH-1:0]  color_q;
   logic                    geo_done;
   logic                    shade_done;
   logic [WD_W-1:0]         wdog;

   logic [CNT_W-1:0]        out_count;
   logic                    fifo_vld;
   result_t                 push_data;
   result_t                 head;

   logic accept;
   logic in_wait;
   logic geo_cap;
   logic shade_cap;
   logic cull;
   logic join_now;
   logic timeout;

   assign ready_out = (state == ST_IDLE) && !rst_in && (out_count < FULL_CNT);
   assign accept    = valid_in && ready_out;
   assign in_wait   = (state == ST_WAIT);
   assign geo_cap   = in_wait && geo_valid_in && !geo_done;
   assign shade_cap = in_wait && shade_valid_in && !shade_done;
   assign cull      = in_wait && (geo_cull_in || shade_cull_in);

   // Results arriving this cycle count toward the join, but a cull in the same cycle overrides it.
   assign join_now  = in_wait && !cull
                      && (geo_done || geo_valid_in)
                      && (shade_done || shade_valid_in);
   assign timeout   = (TIMEOUT_CYCLES != 0) && in_wait && !cull && !join_now
                      && (wdog == WD_LIMIT);

   assign push_data.tri_id = id_q;
   assign push_data.geo    = geo_cap   ? geo_data_in   : geo_q;
   assign push_data.color  = shade_cap ? shade_data_in : color_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= ST_IDLE;
         geo_start_out   <= 1'b0;
         shade_start_out <= 1'b0;
         abort_out       <= 1'b0;
         id_q            <= '0;
         geo_q           <= '0;
         color_q         <= '0;
         geo_done        <= 1'b0;
         shade_done      <= 1'b0;
         wdog            <= '0;
      end else begin
         geo_start_out   <= 1'b0;
         shade_start_out <= 1'b0;
         abort_out       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  id_q            <= tri_id_in;
                  geo_done        <= 1'b0;
                  shade_done      <= 1'b0;
                  wdog            <= '0;
                  geo_start_out   <= 1'b1;
                  shade_start_out <= 1'b1;
                  state           <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cull || timeout) begin
                  abort_out  <= 1'b1;
                  geo_done   <= 1'b0;
                  shade_done <= 1'b0;
                  state      <= ST_IDLE;
               end else if (join_now) begin
                  geo_done   <= 1'b0;
                  shade_done <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  if (geo_cap) begin
                     geo_q    <= geo_data_in;
                     geo_done <= 1'b1;
                  end
                  if (shade_cap) begin
                     color_q    <= shade_data_in;
                     shade_done <= 1'b1;
                  end
                  wdog <= wdog + WD_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tri_out_fifo #(
      .T     (result_t),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (join_now),
      .push_data (push_data),
      .pop       (ready_in),
      .head      (head),
      .not_empty (fifo_vld),
      .count     (out_count)
   );

   assign valid_out  = fifo_vld;
   assign tri_id_out = head.tri_id;
   assign geo_out    = head.geo;
   assign color_out  = head.color;

`ifdef TRI_FORK_JOIN_STATS_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         accepted_count_out <= '0;
         cull_count_out     <= '0;
         timeout_count_out  <= '0;
      end else begin
         if (accept) begin
            accepted_count_out <= sat_inc(accepted_count_out);
         end
         if (cull) begin
            cull_count_out <= sat_inc(cull_count_out);
         end
         if (timeout) begin
            timeout_count_out <= sat_inc(timeout_count_out);
         end
      end
   end
`endif

endmodule

// File: tb/tb_tri_fork_join.sv
// Directed bench for tri_fork_join: join, back-pressure, wrap with push+pop, cull, watchdog, mid-flight reset.
module tb_tri_fork_join;

   logic         clk = 1'b0;
   logic         rst_in;
   logic         valid_in;
   logic         ready_out;
   logic [10:0]  tri_id_in;
   logic         geo_start_out;
   logic         shade_start_out;
   logic         abort_out;
   logic         geo_valid_in;
   logic [167:0] geo_data_in;
   logic         geo_cull_in;
   logic         shade_valid_in;
   logic [15:0]  shade_data_in;
   logic         shade_cull_in;
   logic         valid_out;
   logic         ready_in;
   logic [10:0]  tri_id_out;
   logic [167:0] geo_out;
   logic [15:0]  color_out;
`ifdef TRI_FORK_JOIN_STATS_EN
   logic [15:0]  accepted_count_out;
   logic [15:0]  cull_count_out;
   logic [15:0]  timeout_count_out;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int acc_n  = 0;

   always #5 clk = ~clk;

   tri_fork_join #(.TIMEOUT_CYCLES(8)) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .valid_in        (valid_in),
      .ready_out       (ready_out),
      .tri_id_in       (tri_id_in),
      .geo_start_out   (geo_start_out),
      .shade_start_out (shade_start_out),
      .abort_out       (abort_out),
      .geo_valid_in    (geo_valid_in),
      .geo_data_in     (geo_data_in),
      .geo_cull_in     (geo_cull_in),
      .shade_valid_in  (shade_valid_in),
      .shade_data_in   (shade_data_in),
      .shade_cull_in   (shade_cull_in),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .tri_id_out      (tri_id_out),
      .geo_out         (geo_out),
`ifdef TRI_FORK_JOIN_STATS_EN
      .accepted_count_out (accepted_count_out),
      .cull_count_out     (cull_count_out),
      .timeout_count_out  (timeout_count_out),
`endif
      .color_out       (color_out)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ready, presents one triangle; returns in the start-pulse cycle.
   task automatic accept(input logic [10:0] id);
      int n = 0;
      while (!ready_out && n < 50) begin
         tick();
         n++;
      end
      check("accept_rdy", ready_out, 1);
      valid_in  = 1'b1;
      tri_id_in = id;
      tick();
      valid_in  = 1'b0;
      acc_n++;
   endtask

   // Engine results gl/sl cycles after the start-pulse cycle; returns the cycle after the push.
   task automatic respond(input int gl, input int sl, input logic [167:0] g,
                          input logic [15:0] c, input bit pop_last);
      int mx = (gl > sl) ? gl : sl;
      geo_data_in   = g;
      shade_data_in = c;
      for (int k = 0; k <= mx; k++) begin
         geo_valid_in   = (k == gl);
         shade_valid_in = (k == sl);
         if (k == mx && pop_last) ready_in = 1'b1;
         tick();
      end
      geo_valid_in   = 1'b0;
      shade_valid_in = 1'b0;
      if (pop_last) ready_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int j;
      rst_in = 1'b1; valid_in = 1'b0; tri_id_in = '0; ready_in = 1'b0;
      geo_valid_in = 1'b0; geo_data_in = '0; geo_cull_in = 1'b0;
      shade_valid_in = 1'b0; shade_data_in = '0; shade_cull_in = 1'b0;
      tick();
      tick();
      check("rst_ready", ready_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_abort", abort_out, 0);
      check("rst_gstart", geo_start_out, 0);
      check("rst_sstart", shade_start_out, 0);
      check("rst_id", tri_id_out, 0);
      check("rst_geo", geo_out, 0);
      rst_in = 1'b0;
      tick();
      check("post_rst_ready", ready_out, 1);

      // Basic join: shade at T+1, geo at T+3, output visible at T+4.
      accept(11'd5);
      check("bj_gstart", geo_start_out, 1);
      check("bj_sstart", shade_start_out, 1);
      check("bj_busy", ready_out, 0);
      respond(2, 0, 168'hABC, 16'h1234, 1'b0);
      check("bj_valid", valid_out, 1);
      check("bj_id", tri_id_out, 5);
      check("bj_geo", geo_out, 168'hABC);
      check("bj_color", color_out, 16'h1234);
      check("bj_ready", ready_out, 1);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      check("bj_popped", valid_out, 0);

      // Back-pressure: fill all four slots.
      for (int i = 0; i < 4; i++) begin
         accept(11'(i));
         respond(1, 1, 168'h1000 + 168'(i), 16'(100 + i), 1'b0);
      end
      check("bp_full_rdy", ready_out, 0);
      tick();
      check("bp_still_full", ready_out, 0);
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_vld", valid_out, 1);
         check("bp_id", tri_id_out, i);
         check("bp_color", color_out, 100 + i);
         tick();
      end
      ready_in = 1'b0;
      check("bp_empty", valid_out, 0);
      check("bp_ready_back", ready_out, 1);

      // Push and pop together at count 3, write pointer wraps.
      for (int i = 0; i < 3; i++) begin
         accept(11'(10 + i));
         respond(1, 1, 168'h2000 + 168'(i), 16'(200 + i), 1'b0);
      end
      accept(11'd13);
      respond(1, 2, 168'h2003, 16'd203, 1'b1);
      check("pp_count", dut.out_count, 3);
      ready_in = 1'b1;
      for (int i = 11; i < 14; i++) begin
         check("pp_id", tri_id_out, i);
         check("pp_geo", geo_out, 168'h2000 + 168'(i - 10));
         tick();
      end
      ready_in = 1'b0;
      check("pp_empty", valid_out, 0);

      // Cull with a result valid in the same cycle.
      accept(11'd20);
      geo_valid_in = 1'b1; shade_cull_in = 1'b1;
      tick();
      geo_valid_in = 1'b0; shade_cull_in = 1'b0;
      check("cull_abort", abort_out, 1);
      check("cull_ready", ready_out, 1);
      check("cull_nopush", valid_out, 0);
      tick();
      check("cull_abort_end", abort_out, 0);
      check("cull_nopush2", valid_out, 0);
`ifdef TRI_FORK_JOIN_STATS_EN
      check("cull_cnt1", cull_count_out, 1);
`endif

      // Cull on the completing valid.
      accept(11'd21);
      shade_valid_in = 1'b1;
      tick();
      shade_valid_in = 1'b0; geo_valid_in = 1'b1; geo_cull_in = 1'b1;
      tick();
      geo_valid_in = 1'b0; geo_cull_in = 1'b0;
      check("cull2_abort", abort_out, 1);
      check("cull2_nopush", valid_out, 0);
`ifdef TRI_FORK_JOIN_STATS_EN
      check("cull_cnt2", cull_count_out, 2);
`endif

      // Watchdog with TIMEOUT_CYCLES=8.
      accept(11'd30);
      check("to_start", geo_start_out, 1);
      j = 0;
      while (!abort_out && j < 20) begin
         tick();
         j++;
      end
      check("to_latency", j, 9);
      check("to_ready", ready_out, 1);
`ifdef TRI_FORK_JOIN_STATS_EN
      check("to_cnt", timeout_count_out, 1);
`endif
      accept(11'd31);
      respond(1, 1, 168'h31, 16'h31, 1'b0);
      check("to_next_vld", valid_out, 1);
      check("to_next_id", tri_id_out, 31);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
`ifdef TRI_FORK_JOIN_STATS_EN
      check("acc_cnt", accepted_count_out, acc_n);
`endif

      // Reset while in WAIT with two results queued.
      accept(11'd40);
      respond(1, 1, 168'h40, 16'h40, 1'b0);
      accept(11'd41);
      respond(1, 1, 168'h41, 16'h41, 1'b0);
      accept(11'd42);
      check("rw_two_queued", dut.out_count, 2);
      rst_in = 1'b1;
      tick();
      check("rw_valid", valid_out, 0);
      check("rw_abort", abort_out, 0);
      check("rw_ready_in_rst", ready_out, 0);
      rst_in = 1'b0;
      acc_n  = 0;
      tick();
      check("rw_ready", ready_out, 1);
      check("rw_abort2", abort_out, 0);
      check("rw_valid2", valid_out, 0);
`ifdef TRI_FORK_JOIN_STATS_EN
      check("rw_acc_cnt", accepted_count_out, 0);
`endif

      accept(11'd50);
      respond(0, 1, 168'h50, 16'h50, 1'b0);
      check("rw_after_id", tri_id_out, 50);
      check("rw_after_color", color_out, 16'h50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
